// File: rtl/csi_param_pkg.sv
// Shared types and constants for the CSI-2 lane HS burst sequencer:
// state encoding, the HS sync byte and default protocol timings in byte-clock cycles.
`timescale 1ns/1ps
package csi_param_pkg;

  typedef enum logic [2:0] {
    STOP,
    HS_RQST,
    PREPARE,
    HS_ZERO,
    SYNC,
    PAYLOAD,
    TRAIL,
    EXIT
  } hs_state_t;

  localparam logic [7:0] HS_SYNC_SEQUENCE = 8'b1011_1000;

  localparam int DEF_LPX_CYC     = 4;
  localparam int DEF_PREPARE_CYC = 3;
  localparam int DEF_ZERO_CYC    = 8;
  localparam int DEF_TRAIL_CYC   = 4;
  localparam int DEF_EXIT_CYC    = 7;

  localparam int CNT_W = 16;

  // Phase counter load value for a phase lasting n cycles.
  function automatic logic [CNT_W-1:0] cyc_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/csi_lane_hs_seq.sv
// CSI-2 data-lane HS burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-0 -> sync -> payload -> trail -> LP-11.
// Optional burst/underrun statistics ports are enabled by defining CSI_SEQ_STATS_EN.
`timescale 1ns/1ps
module csi_lane_hs_seq
  import csi_param_pkg::*;
#(
  parameter int LPX_CYC     = DEF_LPX_CYC,
  parameter int PREPARE_CYC = DEF_PREPARE_CYC,
  parameter int ZERO_CYC    = DEF_ZERO_CYC,
  parameter int TRAIL_CYC   = DEF_TRAIL_CYC,
  parameter int EXIT_CYC    = DEF_EXIT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       lp_dp,
  output logic       lp_dn,
  output logic       hs_en,
  output logic [7:0] hs_data,
  output logic       busy,
  output logic       underrun
`ifdef CSI_SEQ_STATS_EN
  ,
  output logic [15:0] burst_cnt,
  output logic [7:0]  underrun_cnt
`endif
);

  if (LPX_CYC < 1 || PREPARE_CYC < 1 || ZERO_CYC < 1 || TRAIL_CYC < 1 || EXIT_CYC < 1) begin : g_param_check
    $error("csi_lane_hs_seq: all cycle-count parameters must be >= 1");
  end

  hs_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [7:0]       r_last_byte;
  logic             r_tx_ready, r_lp_dp, r_lp_dn, r_hs_en, r_busy, r_underrun;
  logic [7:0]       r_hs_data;
  logic             w_lp_dp, w_lp_dn, w_hs_en;
  logic [7:0]       w_hs_data;
  logic             w_cnt_zero, w_accept, w_underrun_det;
  logic [7:0]       w_trail_byte;

  assign w_cnt_zero     = (r_cnt == '0);
  assign w_accept       = r_tx_ready && tx_valid;
  assign w_underrun_det = (r_state == PAYLOAD) && !tx_valid;
  assign w_trail_byte   = {8{~r_last_byte[7]}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STOP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // An underrun cycle already drives the first trail byte, so the TRAIL state is one cycle shorter.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_cnt_zero ? '0 : r_cnt - CNT_W'(1);
    case (r_state)
      STOP:    if (tx_req) begin w_state_next = HS_RQST; w_cnt_next = cyc_load(LPX_CYC); end
      HS_RQST: if (w_cnt_zero) begin w_state_next = PREPARE; w_cnt_next = cyc_load(PREPARE_CYC); end
      PREPARE: if (w_cnt_zero) begin w_state_next = HS_ZERO; w_cnt_next = cyc_load(ZERO_CYC); end
      HS_ZERO: if (w_cnt_zero) begin w_state_next = SYNC; w_cnt_next = cyc_load(1); end
      SYNC:    if (w_cnt_zero) begin w_state_next = PAYLOAD; w_cnt_next = '0; end
      PAYLOAD: begin
        if (!tx_valid) begin
          if (TRAIL_CYC == 1) begin
            w_state_next = EXIT;
            w_cnt_next   = cyc_load(EXIT_CYC);
          end else begin
            w_state_next = TRAIL;
            w_cnt_next   = cyc_load(TRAIL_CYC - 1);
          end
        end else if (tx_last) begin
          w_state_next = TRAIL;
          w_cnt_next   = cyc_load(TRAIL_CYC);
        end
      end
      TRAIL:   if (w_cnt_zero) begin w_state_next = EXIT; w_cnt_next = cyc_load(EXIT_CYC); end
      EXIT:    if (w_cnt_zero) begin w_state_next = STOP; w_cnt_next = '0; end
      default: begin w_state_next = STOP; w_cnt_next = '0; end
    endcase
  end

  // Line image of the current state; registered, so the lane lags the state by one cycle.
  always_comb begin
    w_lp_dp   = 1'b0;
    w_lp_dn   = 1'b0;
    w_hs_en   = 1'b0;
    w_hs_data = 8'h00;
    case (r_state)
      STOP, EXIT: begin w_lp_dp = 1'b1; w_lp_dn = 1'b1; end
      HS_RQST:    w_lp_dn = 1'b1;
      PREPARE:    ;
      HS_ZERO:    w_hs_en = 1'b1;
      SYNC:       begin w_hs_en = 1'b1; w_hs_data = HS_SYNC_SEQUENCE; end
      PAYLOAD:    begin w_hs_en = 1'b1; w_hs_data = tx_valid ? tx_data : w_trail_byte; end
      TRAIL:      begin w_hs_en = 1'b1; w_hs_data = w_trail_byte; end
      default:    begin w_lp_dp = 1'b1; w_lp_dn = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lp_dp    <= 1'b1;
      r_lp_dn    <= 1'b1;
      r_hs_en    <= 1'b0;
      r_hs_data  <= 8'h00;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_lp_dp    <= w_lp_dp;
      r_lp_dn    <= w_lp_dn;
      r_hs_en    <= w_hs_en;
      r_hs_data  <= w_hs_data;
      r_tx_ready <= (w_state_next == PAYLOAD);
      r_busy     <= (w_state_next != STOP);
      r_underrun <= w_underrun_det;
    end
  end

  // Cleared at sync so an empty payload trails as if the last byte were 8'h00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_byte <= 8'h00;
    end else if (r_state == SYNC) begin
      r_last_byte <= 8'h00;
    end else if (w_accept) begin
      r_last_byte <= tx_data;
    end
  end

  assign tx_ready = r_tx_ready;
  assign lp_dp    = r_lp_dp;
  assign lp_dn    = r_lp_dn;
  assign hs_en    = r_hs_en;
  assign hs_data  = r_hs_data;
  assign busy     = r_busy;
  assign underrun = r_underrun;

`ifdef CSI_SEQ_STATS_EN
  logic [15:0] r_burst_cnt;
  logic [7:0]  r_underrun_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_burst_cnt    <= 16'd0;
      r_underrun_cnt <= 8'd0;
    end else begin
      if (r_state == EXIT && w_cnt_zero) r_burst_cnt <= r_burst_cnt + 16'd1;
      if (w_underrun_det && r_underrun_cnt != 8'hFF) r_underrun_cnt <= r_underrun_cnt + 8'd1;
    end
  end

  assign burst_cnt    = r_burst_cnt;
  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_csi_lane_hs_seq.sv
// Directed bench for csi_lane_hs_seq: full burst line traces, trail polarity, underrun,
// back-to-back requests and asynchronous reset mid-burst.
`timescale 1ns/1ps
module tb_csi_lane_hs_seq;

  localparam int LPX   = 4;
  localparam int PREP  = 3;
  localparam int ZERO  = 8;
  localparam int TRAIL = 4;
  localparam int EXITC = 7;
  localparam int HDR   = LPX + PREP + ZERO + 1;

  logic       clk = 1'b0;
  logic       rst, tx_req, tx_valid, tx_last;
  logic [7:0] tx_data;
  logic       tx_ready, lp_dp, lp_dn, hs_en, busy, underrun;
  logic [7:0] hs_data;
`ifdef CSI_SEQ_STATS_EN
  logic [15:0] burst_cnt;
  logic [7:0]  underrun_cnt;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] pay [4];
  int         npay;
  bit         use_last;

  always #5 clk = ~clk;

  csi_lane_hs_seq #(
    .LPX_CYC(LPX), .PREPARE_CYC(PREP), .ZERO_CYC(ZERO), .TRAIL_CYC(TRAIL), .EXIT_CYC(EXITC)
  ) dut (
    .clk(clk), .rst(rst), .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(tx_ready), .lp_dp(lp_dp), .lp_dn(lp_dn), .hs_en(hs_en),
    .hs_data(hs_data), .busy(busy), .underrun(underrun)
`ifdef CSI_SEQ_STATS_EN
    , .burst_cnt(burst_cnt), .underrun_cnt(underrun_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {lp_dp, lp_dn, hs_en, hs_data} for line sample i of a burst emitting n bytes.
  function automatic logic [10:0] exp_line(input int i, input int n, input logic [7:0] last);
    if (i < LPX)                 return {2'b01, 1'b0, 8'h00};
    else if (i < LPX + PREP)     return {2'b00, 1'b0, 8'h00};
    else if (i < HDR - 1)        return {2'b00, 1'b1, 8'h00};
    else if (i == HDR - 1)       return {2'b00, 1'b1, 8'hB8};
    else if (i < HDR + n)        return {2'b00, 1'b1, pay[i - HDR]};
    else if (i < HDR + n + TRAIL) return {2'b00, 1'b1, {8{~last[7]}}};
    else                          return {2'b11, 1'b0, 8'h00};
  endfunction

  task automatic run_burst(input string name, input int n_emit, input bit start_req, input bit keep_req);
    int         idx = 0;
    int         und_cnt = 0;
    int         und_idx = -1;
    int         len;
    logic [7:0] last;
    len  = HDR + n_emit + TRAIL + EXITC;
    last = (n_emit == 0) ? 8'h00 : pay[n_emit - 1];
    if (start_req) begin
      @(negedge clk);
      tx_req = 1'b1;
      @(negedge clk);
    end
    tx_req = keep_req;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check($sformatf("%s_line%0d", name, i), 32'({lp_dp, lp_dn, hs_en, hs_data}),
            32'(exp_line(i, n_emit, last)));
      if (underrun) begin
        und_cnt++;
        if (und_idx < 0) und_idx = i;
      end
      if (tx_ready && idx < npay) begin
        tx_valid = 1'b1;
        tx_data  = pay[idx];
        tx_last  = use_last && (idx == npay - 1);
        idx++;
      end else begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = 8'h00;
      end
    end
    @(negedge clk);
    check({name, "_idle_line"}, 32'({lp_dp, lp_dn, hs_en}), 32'(3'b110));
    check({name, "_busy_after"}, 32'(busy), 32'(keep_req));
    check({name, "_accepted"}, 32'(idx), 32'(npay));
    if (use_last) begin
      check({name, "_no_underrun"}, 32'(und_cnt), 32'd0);
    end else begin
      check({name, "_underrun_pulses"}, 32'(und_cnt), 32'd1);
      check({name, "_underrun_pos"}, 32'(und_idx), 32'(HDR + n_emit));
    end
    $display("burst %s: emitted=%0d accepted=%0d underrun_pulses=%0d", name, n_emit, idx, und_cnt);
  endtask

  initial begin
    rst      = 1'b1;
    tx_req   = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    #1;
    check("reset_line", 32'({lp_dp, lp_dn, hs_en, hs_data}), 32'({2'b11, 1'b0, 8'h00}));
    check("reset_ctrl", 32'({tx_ready, busy, underrun}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'({lp_dp, lp_dn, hs_en, busy}), 32'(4'b1100));

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; npay = 3; use_last = 1'b1;
    run_burst("b3", 3, 1'b1, 1'b0);

    pay[0] = 8'h5A; pay[1] = 8'h80; npay = 2; use_last = 1'b1;
    run_burst("b80", 2, 1'b1, 1'b0);

    pay[0] = 8'hC5; pay[1] = 8'h9E; npay = 2; use_last = 1'b0;
    run_burst("und", 2, 1'b1, 1'b0);

    npay = 0; use_last = 1'b0;
    run_burst("zero", 0, 1'b1, 1'b0);

    pay[0] = 8'h01; pay[1] = 8'hFE; npay = 2; use_last = 1'b1;
    run_burst("hold1", 2, 1'b1, 1'b1);
    pay[0] = 8'h7F; npay = 1; use_last = 1'b1;
    run_burst("hold2", 1, 1'b0, 1'b0);

`ifdef CSI_SEQ_STATS_EN
    check("stats_bursts", 32'(burst_cnt), 32'd6);
    check("stats_underruns", 32'(underrun_cnt), 32'd2);
`endif

    // Asynchronous reset while streaming payload.
    @(negedge clk);
    tx_req = 1'b1;
    @(negedge clk);
    tx_req   = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    tx_last  = 1'b0;
    repeat (HDR + 2) @(negedge clk);
    check("pre_reset_payload", 32'({hs_en, busy, tx_ready, hs_data}), 32'({3'b111, 8'hC3}));
    #2;
    rst = 1'b1;
    #1;
    check("midburst_reset_line", 32'({lp_dp, lp_dn, hs_en, hs_data}), 32'({2'b11, 1'b0, 8'h00}));
    check("midburst_reset_ctrl", 32'({tx_ready, busy, underrun}), 32'd0);
    tx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle%0d", i), 32'({lp_dp, lp_dn, hs_en, busy}), 32'(4'b1100));
    end
`ifdef CSI_SEQ_STATS_EN
    check("stats_reset", 32'({burst_cnt, underrun_cnt}), 32'd0);
`endif
    $display("burst reset_abort: line returned to LP-11 without trail");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
